// File: rtl/rv_pkg.sv
// Shared RV32I definitions: opcodes, ALUOp encodings and the decoded control word.
package rv_pkg;

  localparam logic [6:0] OP_R      = 7'b0110011;
  localparam logic [6:0] OP_I      = 7'b0010011;
  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_JAL    = 7'b1101111;
  localparam logic [6:0] OP_JALR   = 7'b1100111;
  localparam logic [6:0] OP_LUI    = 7'b0110111;
  localparam logic [6:0] OP_AUIPC  = 7'b0010111;

  localparam logic [1:0] ALUOP_ADD    = 2'b00;
  localparam logic [1:0] ALUOP_BRANCH = 2'b01;
  localparam logic [1:0] ALUOP_FUNCT  = 2'b10;

  typedef struct packed {
    logic       jump;
    logic       alu_src;
    logic       mem_to_reg;
    logic       mem_read;
    logic       mem_write;
    logic       branch;
    logic       reg_write;
    logic [1:0] alu_op;
  } ctrl_t;

  localparam ctrl_t CTRL_BUBBLE = '{jump: 1'b0, alu_src: 1'b0, mem_to_reg: 1'b0,
                                    mem_read: 1'b0, mem_write: 1'b0, branch: 1'b0,
                                    reg_write: 1'b0, alu_op: ALUOP_ADD};

endpackage

// File: rtl/hazard_detect.sv
// Load-use hazard detector: flags an ID instruction that reads the register a load in EX writes.
module hazard_detect
  import rv_pkg::*;
(
  input  logic       ex_valid,
  input  logic       ex_mem_read,
  input  logic [4:0] ex_rd,
  input  logic       id_valid,
  input  logic [6:0] id_opcode,
  input  logic [4:0] id_rs1,
  input  logic [4:0] id_rs2,
  input  logic       ex_flush,
  output logic       uses_rs1,
  output logic       uses_rs2,
  output logic       hazard
);

  // rs fields of instructions that do not read them are ignored to avoid false stalls
  assign uses_rs1 = !((id_opcode == OP_JAL) || (id_opcode == OP_LUI) ||
                      (id_opcode == OP_AUIPC));
  assign uses_rs2 = (id_opcode == OP_R) || (id_opcode == OP_STORE) ||
                    (id_opcode == OP_BRANCH);

  assign hazard = ex_valid && ex_mem_read && (ex_rd != 5'd0) && id_valid &&
                  ((uses_rs1 && (ex_rd == id_rs1)) || (uses_rs2 && (ex_rd == id_rs2))) &&
                  !ex_flush;

endmodule

// File: rtl/id_ex_stage.sv
// ID/EX pipeline register with load-use stall, EX flush handling and a stall counter.
module id_ex_stage
  import rv_pkg::*;
#(
  parameter int XLEN = 32
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            id_valid,
  input  logic [6:0]      id_opcode,
  input  logic            id_jump,
  input  logic            id_alu_src,
  input  logic            id_mem_to_reg,
  input  logic            id_mem_read,
  input  logic            id_mem_write,
  input  logic            id_branch,
  input  logic            id_reg_write,
  input  logic [1:0]      id_alu_op,
  input  logic [XLEN-1:0] id_pc,
  input  logic [XLEN-1:0] id_rs1_data,
  input  logic [XLEN-1:0] id_rs2_data,
  input  logic [XLEN-1:0] id_imm,
  input  logic [4:0]      id_rs1,
  input  logic [4:0]      id_rs2,
  input  logic [4:0]      id_rd,
  input  logic [2:0]      id_funct3,
  input  logic            id_funct7b5,
  input  logic            ex_flush,
  output logic            ex_valid,
  output logic [6:0]      ex_opcode,
  output logic            ex_jump,
  output logic            ex_alu_src,
  output logic            ex_mem_to_reg,
  output logic            ex_mem_read,
  output logic            ex_mem_write,
  output logic            ex_branch,
  output logic            ex_reg_write,
  output logic [1:0]      ex_alu_op,
  output logic [XLEN-1:0] ex_pc,
  output logic [XLEN-1:0] ex_rs1_data,
  output logic [XLEN-1:0] ex_rs2_data,
  output logic [XLEN-1:0] ex_imm,
  output logic [4:0]      ex_rs1,
  output logic [4:0]      ex_rs2,
  output logic [4:0]      ex_rd,
  output logic [2:0]      ex_funct3,
  output logic            ex_funct7b5,
  output logic            pc_write,
  output logic            if_id_write,
  output logic [31:0]     stall_count
);

  function automatic logic [31:0] sat_inc(input logic [31:0] v);
    return (v == 32'hFFFF_FFFF) ? v : v + 32'd1;
  endfunction

  ctrl_t            ctrl_p0;
  ctrl_t            ctrl_id;
  logic             vld_p0;
  logic [6:0]       opcode_p0;
  logic [XLEN-1:0]  pc_p0, rs1_data_p0, rs2_data_p0, imm_p0;
  logic [4:0]       rs1_p0, rs2_p0, rd_p0;
  logic [2:0]       funct3_p0;
  logic             funct7b5_p0;
  logic [31:0]      stall_cnt;
  logic             uses_rs1, uses_rs2, hazard;

  assign ctrl_id = '{jump: id_jump, alu_src: id_alu_src, mem_to_reg: id_mem_to_reg,
                     mem_read: id_mem_read, mem_write: id_mem_write, branch: id_branch,
                     reg_write: id_reg_write, alu_op: id_alu_op};

  hazard_detect u_hazard (
    .ex_valid    (vld_p0),
    .ex_mem_read (ctrl_p0.mem_read),
    .ex_rd       (rd_p0),
    .id_valid    (id_valid),
    .id_opcode   (id_opcode),
    .id_rs1      (id_rs1),
    .id_rs2      (id_rs2),
    .ex_flush    (ex_flush),
    .uses_rs1    (uses_rs1),
    .uses_rs2    (uses_rs2),
    .hazard      (hazard)
  );

  assign pc_write    = !hazard;
  assign if_id_write = !hazard;

  // ID -> EX boundary; bubbles clear control only and leave the data fields as they were
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      vld_p0      <= 1'b0;
      ctrl_p0     <= CTRL_BUBBLE;
      opcode_p0   <= '0;
      pc_p0       <= '0;
      rs1_data_p0 <= '0;
      rs2_data_p0 <= '0;
      imm_p0      <= '0;
      rs1_p0      <= '0;
      rs2_p0      <= '0;
      rd_p0       <= '0;
      funct3_p0   <= '0;
      funct7b5_p0 <= 1'b0;
    end else if (ex_flush || hazard) begin
      vld_p0  <= 1'b0;
      ctrl_p0 <= CTRL_BUBBLE;
    end else begin
      vld_p0      <= id_valid;
      ctrl_p0     <= ctrl_id;
      opcode_p0   <= id_opcode;
      pc_p0       <= id_pc;
      rs1_data_p0 <= id_rs1_data;
      rs2_data_p0 <= id_rs2_data;
      imm_p0      <= id_imm;
      rs1_p0      <= id_rs1;
      rs2_p0      <= id_rs2;
      rd_p0       <= id_rd;
      funct3_p0   <= id_funct3;
      funct7b5_p0 <= id_funct7b5;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)      stall_cnt <= '0;
    else if (hazard) stall_cnt <= sat_inc(stall_cnt);
  end

  assign ex_valid      = vld_p0;
  assign ex_opcode     = opcode_p0;
  assign ex_jump       = ctrl_p0.jump;
  assign ex_alu_src    = ctrl_p0.alu_src;
  assign ex_mem_to_reg = ctrl_p0.mem_to_reg;
  assign ex_mem_read   = ctrl_p0.mem_read;
  assign ex_mem_write  = ctrl_p0.mem_write;
  assign ex_branch     = ctrl_p0.branch;
  assign ex_reg_write  = ctrl_p0.reg_write;
  assign ex_alu_op     = ctrl_p0.alu_op;
  assign ex_pc         = pc_p0;
  assign ex_rs1_data   = rs1_data_p0;
  assign ex_rs2_data   = rs2_data_p0;
  assign ex_imm        = imm_p0;
  assign ex_rs1        = rs1_p0;
  assign ex_rs2        = rs2_p0;
  assign ex_rd         = rd_p0;
  assign ex_funct3     = funct3_p0;
  assign ex_funct7b5   = funct7b5_p0;
  assign stall_count   = stall_cnt;

  // uses_rs1/uses_rs2 are exposed by the detector for debug visibility only
  logic unused_uses;
  assign unused_uses = uses_rs1 ^ uses_rs2;

endmodule

// File: tb/tb_id_ex_stage.sv
// Scoreboard bench for id_ex_stage: a reference model pushes expected EX state, popped after each edge.
module tb_id_ex_stage;

  typedef struct packed {
    logic        valid;
    logic [8:0]  ctrl;
    logic [6:0]  op;
    logic [31:0] pc, rs1d, rs2d, imm;
    logic [4:0]  rs1, rs2, rd;
    logic [2:0]  f3;
    logic        f7;
    logic [31:0] stall;
  } exp_t;

  localparam logic [6:0] LOAD = 7'b0000011, R = 7'b0110011, STORE = 7'b0100011;
  localparam logic [6:0] JAL = 7'b1101111, OPI = 7'b0010011, BR = 7'b1100011;
  localparam logic [6:0] LUI = 7'b0110111, AUIPC = 7'b0010111;
  // {jump, alu_src, mem_to_reg, mem_read, mem_write, branch, reg_write, alu_op}
  localparam logic [8:0] C_LW = 9'b011100100, C_ADD = 9'b000000110, C_SW = 9'b010010000;
  localparam logic [8:0] C_JAL = 9'b100000100, C_ADDI = 9'b010000110, C_BEQ = 9'b000001001;

  logic clk = 1'b0, rst_n = 1'b0;
  logic id_valid = 1'b0, ex_flush = 1'b0;
  logic [6:0] id_opcode = '0;
  logic id_jump = 0, id_alu_src = 0, id_mem_to_reg = 0, id_mem_read = 0;
  logic id_mem_write = 0, id_branch = 0, id_reg_write = 0;
  logic [1:0] id_alu_op = '0;
  logic [31:0] id_pc = '0, id_rs1_data = '0, id_rs2_data = '0, id_imm = '0;
  logic [4:0] id_rs1 = '0, id_rs2 = '0, id_rd = '0;
  logic [2:0] id_funct3 = '0;
  logic id_funct7b5 = 1'b0;

  logic ex_valid, ex_jump, ex_alu_src, ex_mem_to_reg, ex_mem_read, ex_mem_write;
  logic ex_branch, ex_reg_write, ex_funct7b5, pc_write, if_id_write;
  logic [6:0] ex_opcode;
  logic [1:0] ex_alu_op;
  logic [31:0] ex_pc, ex_rs1_data, ex_rs2_data, ex_imm, stall_count;
  logic [4:0] ex_rs1, ex_rs2, ex_rd;
  logic [2:0] ex_funct3;

  int checks = 0, errors = 0;
  exp_t m;
  exp_t q[$];

  always #5 clk = ~clk;

  id_ex_stage #(.XLEN(32)) dut (
    .clk(clk), .rst_n(rst_n), .id_valid(id_valid), .id_opcode(id_opcode),
    .id_jump(id_jump), .id_alu_src(id_alu_src), .id_mem_to_reg(id_mem_to_reg),
    .id_mem_read(id_mem_read), .id_mem_write(id_mem_write), .id_branch(id_branch),
    .id_reg_write(id_reg_write), .id_alu_op(id_alu_op), .id_pc(id_pc),
    .id_rs1_data(id_rs1_data), .id_rs2_data(id_rs2_data), .id_imm(id_imm),
    .id_rs1(id_rs1), .id_rs2(id_rs2), .id_rd(id_rd), .id_funct3(id_funct3),
    .id_funct7b5(id_funct7b5), .ex_flush(ex_flush), .ex_valid(ex_valid),
    .ex_opcode(ex_opcode), .ex_jump(ex_jump), .ex_alu_src(ex_alu_src),
    .ex_mem_to_reg(ex_mem_to_reg), .ex_mem_read(ex_mem_read),
    .ex_mem_write(ex_mem_write), .ex_branch(ex_branch), .ex_reg_write(ex_reg_write),
    .ex_alu_op(ex_alu_op), .ex_pc(ex_pc), .ex_rs1_data(ex_rs1_data),
    .ex_rs2_data(ex_rs2_data), .ex_imm(ex_imm), .ex_rs1(ex_rs1), .ex_rs2(ex_rs2),
    .ex_rd(ex_rd), .ex_funct3(ex_funct3), .ex_funct7b5(ex_funct7b5),
    .pc_write(pc_write), .if_id_write(if_id_write), .stall_count(stall_count)
  );

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  function automatic logic [8:0] dut_ctrl();
    return {ex_jump, ex_alu_src, ex_mem_to_reg, ex_mem_read, ex_mem_write,
            ex_branch, ex_reg_write, ex_alu_op};
  endfunction

  task automatic check_reset(input string tag);
    check({tag, "_valid"}, 64'(ex_valid), 64'd0);
    check({tag, "_ctrl"}, 64'(dut_ctrl()), 64'd0);
    check({tag, "_data"}, {ex_pc, ex_imm} | {ex_rs1_data, ex_rs2_data}, 64'd0);
    check({tag, "_idx"}, 64'({ex_rs1, ex_rs2, ex_rd, ex_funct3, ex_funct7b5, ex_opcode}), 64'd0);
    check({tag, "_stall"}, 64'(stall_count), 64'd0);
    check({tag, "_pcw"}, 64'({pc_write, if_id_write}), 64'd3);
  endtask

  // Called at posedge+1: drive ID, check stall outputs, predict and check the next EX state.
  task automatic step(input string tag, input logic v, input logic [6:0] op,
                      input logic [8:0] c, input logic [4:0] rs1, input logic [4:0] rs2,
                      input logic [4:0] rd, input logic [31:0] imm, input logic [31:0] pc,
                      input logic fl);
    logic u1, u2, haz;
    exp_t e;
    id_valid = v; id_opcode = op; ex_flush = fl;
    {id_jump, id_alu_src, id_mem_to_reg, id_mem_read, id_mem_write,
     id_branch, id_reg_write, id_alu_op} = c;
    id_rs1 = rs1; id_rs2 = rs2; id_rd = rd; id_imm = imm; id_pc = pc;
    id_rs1_data = $urandom; id_rs2_data = $urandom;
    id_funct3 = 3'($urandom); id_funct7b5 = 1'($urandom);
    u1 = !(op == JAL || op == LUI || op == AUIPC);
    u2 = (op == R || op == STORE || op == BR);
    haz = m.valid && m.ctrl[5] && (m.rd != 5'd0) && v &&
          ((u1 && m.rd == rs1) || (u2 && m.rd == rs2)) && !fl;
    #3;
    check({tag, "_pc_write"}, 64'(pc_write), 64'(!haz));
    check({tag, "_if_id_write"}, 64'(if_id_write), 64'(!haz));
    if (fl || haz) begin
      m.valid = 1'b0; m.ctrl = '0;
    end else begin
      m.valid = v; m.ctrl = c; m.op = op; m.pc = pc; m.imm = imm;
      m.rs1d = id_rs1_data; m.rs2d = id_rs2_data; m.rs1 = rs1; m.rs2 = rs2;
      m.rd = rd; m.f3 = id_funct3; m.f7 = id_funct7b5;
    end
    if (haz && m.stall != 32'hFFFF_FFFF) m.stall = m.stall + 1;
    q.push_back(m);
    @(posedge clk);
    #1;
    e = q.pop_front();
    check({tag, "_ex_valid"}, 64'(ex_valid), 64'(e.valid));
    check({tag, "_ctrl"}, 64'(dut_ctrl()), 64'(e.ctrl));
    check({tag, "_stall_count"}, 64'(stall_count), 64'(e.stall));
    if (e.valid) begin
      check({tag, "_pc_imm"}, {ex_pc, ex_imm}, {e.pc, e.imm});
      check({tag, "_rdata"}, {ex_rs1_data, ex_rs2_data}, {e.rs1d, e.rs2d});
      check({tag, "_idx"}, 64'({ex_rs1, ex_rs2, ex_rd, ex_funct3, ex_funct7b5, ex_opcode}),
            64'({e.rs1, e.rs2, e.rd, e.f3, e.f7, e.op}));
    end
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    m = '0;
    #2;
    check_reset("reset");
    @(posedge clk); #1;
    rst_n = 1'b1;

    step("lw_x5",    1, LOAD, C_LW,  5'd1, 5'd0, 5'd5, 32'd4, 32'h100, 0);
    step("add_haz",  1, R,    C_ADD, 5'd5, 5'd7, 5'd6, 32'd0, 32'h104, 0);
    step("add_go",   1, R,    C_ADD, 5'd5, 5'd7, 5'd6, 32'd0, 32'h104, 0);
    check("add_rs1", 64'(ex_rs1), 64'd5);
    check("add_stall", 64'(stall_count), 64'd1);

    step("lw_x0",    1, LOAD, C_LW,  5'd1, 5'd0, 5'd0, 32'd0, 32'h108, 0);
    step("use_x0",   1, R,    C_ADD, 5'd0, 5'd0, 5'd3, 32'd0, 32'h10c, 0);
    step("lw_x5b",   1, LOAD, C_LW,  5'd1, 5'd0, 5'd5, 32'd0, 32'h110, 0);
    step("jal",      1, JAL,  C_JAL, 5'd5, 5'd5, 5'd1, 32'h20, 32'h114, 0);
    step("lw_x5c",   1, LOAD, C_LW,  5'd1, 5'd0, 5'd5, 32'd0, 32'h118, 0);
    step("addi",     1, OPI,  C_ADDI, 5'd7, 5'd5, 5'd6, 32'd1, 32'h11c, 0);

    step("flush",    1, R,    C_ADD, 5'd1, 5'd2, 5'd3, 32'd0, 32'h120, 1);
    step("lw_x5d",   1, LOAD, C_LW,  5'd1, 5'd0, 5'd5, 32'd0, 32'h124, 0);
    step("flush_hz", 1, R,    C_ADD, 5'd5, 5'd7, 5'd6, 32'd0, 32'h128, 1);

    step("sw",       1, STORE, C_SW, 5'd2, 5'd3, 5'd0, 32'h10, 32'h40, 0);
    check("sw_mem_write", 64'(ex_mem_write), 64'd1);
    check("sw_alu_src", 64'(ex_alu_src), 64'd1);
    check("sw_alu_op", 64'(ex_alu_op), 64'd0);
    check("sw_imm_pc", {ex_imm, ex_pc}, {32'h10, 32'h40});

    step("flush2a",  1, BR,   C_BEQ, 5'd1, 5'd2, 5'd0, 32'h8, 32'h44, 1);
    step("flush2b",  1, R,    C_ADD, 5'd1, 5'd2, 5'd3, 32'd0, 32'h48, 1);
    step("novalid",  0, R,    C_ADD, 5'd1, 5'd2, 5'd3, 32'd0, 32'h4c, 0);
    check("novalid_rw", 64'(ex_reg_write), 64'd1);
    step("lw_x5e",   1, LOAD, C_LW,  5'd1, 5'd0, 5'd5, 32'd0, 32'h50, 0);
    step("sw_haz",   1, STORE, C_SW, 5'd2, 5'd5, 5'd0, 32'h4, 32'h54, 0);
    step("sw_go",    1, STORE, C_SW, 5'd2, 5'd5, 5'd0, 32'h4, 32'h54, 0);

    for (int i = 0; i < 60; i++) begin
      logic [6:0] op;
      logic [8:0] c;
      case ($urandom_range(0, 4))
        0: begin op = LOAD;  c = C_LW;  end
        1: begin op = R;     c = C_ADD; end
        2: begin op = STORE; c = C_SW;  end
        3: begin op = BR;    c = C_BEQ; end
        default: begin op = LUI; c = C_ADDI; end
      endcase
      step("rand", 1'($urandom_range(0, 7) != 0), op, c, 5'($urandom_range(0, 3)),
           5'($urandom_range(0, 3)), 5'($urandom_range(0, 3)), $urandom, $urandom,
           1'($urandom_range(0, 7) == 0));
    end

    step("pre_rst",  1, LOAD, C_LW,  5'd1, 5'd0, 5'd5, 32'd0, 32'h200, 0);
    id_valid = 1'b1; id_opcode = R; id_rs1 = 5'd5;
    #2;
    rst_n = 1'b0;
    #1;
    check_reset("midrst");
    @(posedge clk); #1;
    rst_n = 1'b1;
    m = '0;
    step("post_rst", 1, R,    C_ADD, 5'd5, 5'd7, 5'd6, 32'd0, 32'h204, 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
